// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch memory path.
package fetch_pkg;

  typedef enum logic [1:0] {
    MODE_BOOT = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_RUN  = 2'd2
  } mode_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive deferred loader cycles; hit marks the forced-slot point.
module imem_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] count;

  assign hit = (count == CW'(STARVE_LIMIT));

  // clear has priority; the count never runs past the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !hit) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory controller: BOOT/LOAD/RUN mode machine with
// loader-vs-fetch arbitration and a starvation bound on deferred loader writes.
module imem_port_arbiter
  import fetch_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_done,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_misalign,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        mode,
  output logic [ADDR_W:0]   wr_ptr
);

  mode_e             mode_r;
  mode_e             next_mode;
  logic              full;
  logic              ld_slot;
  logic              wr_fire;
  logic              starve_hit;
  logic              starve_clr;
  logic              starve_inc;
  logic [DATA_W-1:0] rdata_hold;
  logic              unused_addr;

  // wr_ptr saturates at exactly the memory depth, so its MSB alone means full
  assign full        = wr_ptr[ADDR_W];
  assign mode        = mode_r;
  assign unused_addr = ^fetch_addr[31:ADDR_W+2];

  always_comb begin
    next_mode = mode_r;
    if (load_start) begin
      next_mode = MODE_LOAD;
    end else if (load_done) begin
      next_mode = MODE_RUN;
    end else begin
      next_mode = mode_r;
    end
  end

  always_comb begin
    ld_slot   = 1'b0;
    ld_ready  = 1'b0;
    fetch_gnt = 1'b0;
    case (mode_r)
      MODE_LOAD: begin
        ld_ready = !full;
      end
      MODE_RUN: begin
        ld_slot   = ld_valid && !full && (!fetch_req || starve_hit);
        ld_ready  = ld_slot;
        fetch_gnt = fetch_req && !ld_slot;
      end
      default: begin
        ld_ready  = 1'b0;
        fetch_gnt = 1'b0;
      end
    endcase

    wr_fire   = ld_valid && ld_ready;
    mem_en    = wr_fire || fetch_gnt;
    mem_we    = wr_fire;
    mem_wdata = wr_fire ? ld_data : '0;
    if (wr_fire) begin
      mem_addr = wr_ptr[ADDR_W-1:0];
    end else if (fetch_gnt) begin
      mem_addr = fetch_addr[ADDR_W+1:2];
    end else begin
      mem_addr = '0;
    end
  end

  // Any mode change, an absent loader or a granted loader slot restarts the wait count
  assign starve_clr = (mode_r != MODE_RUN) || (next_mode != mode_r) || !ld_valid || ld_slot;
  assign starve_inc = (mode_r == MODE_RUN) && ld_valid && fetch_req && !ld_slot && !full;

  imem_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (starve_clr),
    .inc (starve_inc),
    .hit (starve_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= MODE_BOOT;
      wr_ptr <= '0;
    end else begin
      mode_r <= next_mode;
      if (load_start) begin
        wr_ptr <= '0;
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
      end
    end
  end

  // Read return path: data is live from the memory on the valid cycle, held afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_rvalid   <= 1'b0;
      fetch_misalign <= 1'b0;
      rdata_hold     <= '0;
    end else begin
      fetch_rvalid   <= fetch_gnt;
      fetch_misalign <= fetch_gnt && (fetch_addr[1:0] != 2'b00);
      if (fetch_rvalid) begin
        rdata_hold <= mem_rdata;
      end
    end
  end

  assign fetch_rdata = fetch_rvalid ? mem_rdata : rdata_hold;

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Controller for the single-port instruction memory behind the fetch stage. It arbitrates between two requesters: the fetch path, which reads one word per granted cycle, and a program loader that streams words in at boot or patches memory at run time. A three-state mode machine (BOOT / LOAD / RUN) sequences the memory. In RUN, a starvation counter bounds how long a loader write can be deferred.

## Interface
- ADDR_W, 8, word-address width; memory depth 2**ADDR_W words
- DATA_W, 32, instruction word width
- STARVE_LIMIT, 4, consecutive deferred loader cycles before the loader is forced a slot (≥1)

- Clk  in  1  clock, all state on posedge
- Rst  in  1  reset, asynchronous, active-high
- load_start  in  1  pulse: enter LOAD, clear write pointer
- load_done  in  1  pulse: enter RUN
- ld_valid  in  1  loader word present
- ld_data  in  DATA_W  loader word
- ld_ready  out  1  loader word accepted this cycle when ld_valid&ld_ready
- fetch_req  in  1  fetch wants a read this cycle
- fetch_addr  in  32  byte address; bits [ADDR_W+1:2] used
- fetch_gnt  out  1  read issued this cycle
- fetch_rvalid  out  1  fetch_rdata valid (one cycle after fetch_gnt)
- fetch_rdata  out  DATA_W  read data
- fetch_misalign  out  1  registered: granted address had [1:0]≠0
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  synchronous read data, 1-cycle latency
- mode  out  2  BOOT=0, LOAD=1, RUN=2
- wr_ptr  out  ADDR_W+1  words written since last load_start

## Operation
- Reset: mode=BOOT, wr_ptr=0, starve=0, fetch_rvalid=0, fetch_rdata=0, fetch_misalign=0. Combinational outputs are 0 in BOOT.
- Transitions:
  - BOOT→LOAD on load_start; BOOT→RUN on load_done.
  - LOAD→RUN on load_done.
  - RUN→LOAD on load_start.
  - load_start wins if both are asserted. Any load_start clears wr_ptr to 0.
- BOOT: fetch_gnt=0, ld_ready=0.
- LOAD:
  - fetch_gnt=0.
  - ld_ready=1 unless full (wr_ptr==2**ADDR_W).
  - Each accepted beat drives mem_en=1, mem_we=1, mem_addr=wr_ptr[ADDR_W-1:0], mem_wdata=ld_data, then wr_ptr+=1.
  - When full, ld_ready=0; wr_ptr saturates and never wraps.
- RUN:
  - Loader slot (ld_slot) = ld_valid & !full & (!fetch_req | starve==STARVE_LIMIT).
  - ld_ready = ld_slot. A loader write proceeds as in LOAD.
  - fetch_gnt = fetch_req & !ld_slot. A grant drives mem_en=1, mem_we=0, mem_addr=fetch_addr[ADDR_W+1:2].
  - starve increments when ld_valid & fetch_req & !ld_slot & !full.
  - starve clears on ld_slot, on !ld_valid, and on any mode change.
- fetch_rdata equals mem_rdata in the cycle fetch_rvalid=1. It holds its last value otherwise, so it is registered on capture.

## Timing
- Read latency: address at grant edge N; fetch_rvalid and fetch_rdata valid in cycle N+1.
- Write latency: memory updated at the accept edge; a fetch of the same address granted in the next cycle returns the new word.
- ld_ready and fetch_gnt are combinational from the current mode and inputs. The loader must hold ld_data while ld_valid is high and ld_ready is low.
- Worst-case loader wait in RUN with fetch_req held high: STARVE_LIMIT cycles, accepted in cycle STARVE_LIMIT+1. The fetch is stalled exactly that one cycle.
- Reset asserted mid-LOAD: the mode returns to BOOT immediately. A partially written memory is not cleared. An in-flight fetch_rvalid is dropped.
- Full and load_done in the same cycle: go to RUN, with no write.

## Structure
- Shared package fetch_pkg holds:
  - the mode enum (BOOT/LOAD/RUN, 2 bits)
  - the default ADDR_W and DATA_W constants
- One natural sub-module: imem_starve_ctr, a saturating counter with clear and a hit flag at STARVE_LIMIT.
- The arbitration logic and the mode machine stay in the top module.

## Test plan
- Reset, load_start, then stream 3 words 0xAAAA0001..3 with ld_valid high → wr_ptr=3 and memory words 0..2 written. After load_done, mode=RUN; a fetch at 0x8 returns 0xAAAA0003 one cycle after grant.
- In BOOT, pulse fetch_req → fetch_gnt=0 and ld_ready=0. Then load_done → RUN, and the fetch is granted.
- In RUN, hold fetch_req=1 and ld_valid=1 with STARVE_LIMIT=4 → 4 grants, then 1 loader write (fetch_gnt=0), then grants resume and starve=0.
- With ADDR_W=2, stream 5 words → 4 accepted, ld_ready=0 on the 5th, and wr_ptr=4 held.
- Write 0x1234 to word 5 in RUN while fetch_req=0, then fetch 0x14 next cycle → fetch_rdata=0x1234. A fetch at 0x15 also sets fetch_misalign=1.
- Assert Rst mid-LOAD after 2 beats → mode=BOOT, wr_ptr=0, ld_ready=0 immediately. A following load_start restarts at word 0.
